// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : servo_pkg
// Description : Shared state encoding, default timing constants and the
//               center-width helper for the servo pulse generator.
// Revision    : 1.0
// ============================================================================
package servo_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_high = 2'd1;
    localparam state_t c_st_low  = 2'd2;

    localparam int c_frame_ticks = 5000;
    localparam int c_min_ticks   = 250;
    localparam int c_pos_max     = 250;

    // Pulse width, in ticks, for the middle of the position range.
    function automatic int center_width(input int min_ticks, input int pos_max);
        return min_ticks + pos_max / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_pos_buffer.sv
`default_nettype none
// ============================================================================
// Module      : servo_pos_buffer
// Description : Single-entry position command buffer with valid/ready,
//               clamping to POS_MAX, and a load strobe that empties it.
// Revision    : 1.0
// ============================================================================
module servo_pos_buffer
    import servo_pkg::*;
#(
    parameter int POS_W   = 8,
    parameter int POS_MAX = c_pos_max
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [POS_W-1:0] pos_data,
    input  logic             pos_valid,
    output logic             pos_ready,
    input  logic             load,
    output logic             full,
    output logic [POS_W-1:0] pending
);

    logic             r_full;
    logic [POS_W-1:0] r_pending;
    logic             w_accept;
    logic [POS_W-1:0] w_clamped;

    assign w_accept  = pos_valid & ~r_full;
    assign w_clamped = (pos_data > POS_W'(POS_MAX)) ? POS_W'(POS_MAX) : pos_data;

    // A capture in the same cycle as a load keeps the slot full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full    <= 1'b0;
            r_pending <= '0;
        end else if (w_accept) begin
            r_full    <= 1'b1;
            r_pending <= w_clamped;
        end else if (load) begin
            r_full    <= 1'b0;
        end
    end

    assign pos_ready = ~r_full;
    assign full      = r_full;
    assign pending   = r_pending;

endmodule
`default_nettype wire

// File: rtl/servo_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_gen
// Description : Tick-enabled servo frame/pulse generator; commands load only at
//               frame boundaries. Optional failsafe: SERVO_PWM_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int FRAME_TICKS = c_frame_ticks,
    parameter int MIN_TICKS   = c_min_ticks,
    parameter int POS_MAX     = c_pos_max,
    parameter int POS_W       = 8,
    parameter int CNT_W       = 13
`ifdef SERVO_PWM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_FRAMES = 50
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_en,
    input  logic             en,
    input  logic [POS_W-1:0] pos_data,
    input  logic             pos_valid,
    output logic             pos_ready,
    output logic             pwm_out,
    output logic             frame_start,
    output logic             busy,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] c_last_tick = CNT_W'(FRAME_TICKS - 1);
    localparam logic [CNT_W-1:0] c_center    = CNT_W'(center_width(MIN_TICKS, POS_MAX));
    localparam logic [CNT_W-1:0] c_min       = CNT_W'(MIN_TICKS);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_width;
    logic             r_pwm;
    logic             r_frame_start;
    logic             r_busy;

    logic             w_frame_go;
    logic             w_load;
    logic             w_expire;
    logic             w_buf_full;
    logic [POS_W-1:0] w_pending;

    assign w_frame_go = tick_en & en &
                        ((r_state == c_st_idle) |
                         ((r_state == c_st_low) & (r_cnt == c_last_tick)));
    assign w_load     = w_frame_go & w_buf_full;

    servo_pos_buffer #(
        .POS_W   (POS_W),
        .POS_MAX (POS_MAX)
    ) u_pos_buffer (
        .clk       (clk),
        .rst       (rst),
        .pos_data  (pos_data),
        .pos_valid (pos_valid),
        .pos_ready (pos_ready),
        .load      (w_load),
        .full      (w_buf_full),
        .pending   (w_pending)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_width <= c_center;
        end else if (w_load) begin
            r_width <= c_min + CNT_W'(w_pending);
        end else if (w_expire) begin
            r_width <= c_center;
        end
    end

`ifdef SERVO_PWM_TIMEOUT_EN
    localparam int c_fc_w = $clog2(TIMEOUT_FRAMES + 1);

    logic [c_fc_w-1:0] r_frames;
    logic              r_timeout;

    // Fires on the frame start that completes TIMEOUT_FRAMES empty frames.
    assign w_expire = w_frame_go & ~w_buf_full &
                      (r_frames >= c_fc_w'(TIMEOUT_FRAMES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frames  <= '0;
            r_timeout <= 1'b0;
        end else if (w_load) begin
            r_frames  <= '0;
            r_timeout <= 1'b0;
        end else if (w_frame_go) begin
            if (r_frames != c_fc_w'(TIMEOUT_FRAMES)) begin
                r_frames <= r_frames + 1'b1;
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_cnt         <= '0;
            r_pwm         <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (tick_en) begin
                case (r_state)
                    c_st_idle: begin
                        if (en) begin
                            r_state       <= c_st_high;
                            r_cnt         <= '0;
                            r_pwm         <= 1'b1;
                            r_busy        <= 1'b1;
                            r_frame_start <= 1'b1;
                        end
                    end
                    c_st_high: begin
                        r_cnt <= r_cnt + c_one;
                        if (r_cnt == r_width - c_one) begin
                            r_state <= c_st_low;
                            r_pwm   <= 1'b0;
                        end
                    end
                    c_st_low: begin
                        if (r_cnt == c_last_tick) begin
                            r_cnt <= '0;
                            if (en) begin
                                r_state       <= c_st_high;
                                r_pwm         <= 1'b1;
                                r_frame_start <= 1'b1;
                            end else begin
                                r_state <= c_st_idle;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + c_one;
                        end
                    end
                    default: begin
                        r_state <= c_st_idle;
                        r_cnt   <= '0;
                        r_pwm   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pwm_out     = r_pwm;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_servo_pwm_gen
// Description : Self-checking bench for servo_pwm_gen: directed pulse-width
//               vectors plus randomized traffic against a frame-level model.
// Revision    : 1.0
// ============================================================================
module tb_servo_pwm_gen;

    localparam int c_frame   = 5000;
    localparam int c_min     = 250;
    localparam int c_pos_max = 250;
    localparam int c_center  = 375;
`ifdef SERVO_PWM_TIMEOUT_EN
    localparam int c_timeout_frames = 50;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_en;
    logic       en;
    logic [7:0] pos_data;
    logic       pos_valid;
    logic       pos_ready;
    logic       pwm_out;
    logic       frame_start;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;
    int tick_mode = 0;
    int tick_phase = 0;

    // Frame-level reference: position inside the frame, not FSM states.
    bit m_active, m_full, m_fs, m_to;
    int m_idx, m_width, m_pend, m_frames;

    typedef struct {
        logic [7:0] pos;
        int         width;
    } vec_t;
    vec_t vecs [5];

    servo_pwm_gen dut (
        .clk         (clk),
        .rst         (rst),
        .tick_en     (tick_en),
        .en          (en),
        .pos_data    (pos_data),
        .pos_valid   (pos_valid),
        .pos_ready   (pos_ready),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .busy        (busy),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_full = 0; m_fs = 0; m_to = 0;
        m_idx = 0; m_width = c_center; m_pend = 0; m_frames = 0;
    endtask

    task automatic model_step();
        bit go, fullb;
        fullb = m_full;
        go = tick_en && en && (!m_active || m_idx == c_frame - 1);
        m_fs = go;
        if (go) begin
            m_active = 1;
            m_idx = 0;
            if (fullb) begin
                m_width = c_min + m_pend;
                m_full = 0;
                m_frames = 0;
                m_to = 0;
            end else begin
`ifdef SERVO_PWM_TIMEOUT_EN
                m_frames = m_frames + 1;
                if (m_frames >= c_timeout_frames) begin
                    m_width = c_center;
                    m_to = 1;
                end
`endif
            end
        end else if (tick_en && m_active) begin
            if (m_idx == c_frame - 1) m_active = 0;
            else m_idx++;
        end
        if (pos_valid && !fullb) begin
            m_pend = (pos_data > c_pos_max) ? c_pos_max : int'(pos_data);
            m_full = 1;
        end
    endtask

    always @(negedge clk) begin
        if (rst) model_reset();
        check("model_outputs", {pwm_out, frame_start, busy, pos_ready, timeout},
              {(m_active && m_idx < m_width), m_fs, m_active, !m_full, m_to});
        if (!rst) model_step();
    end

    task automatic step();
        @(posedge clk);
        #1;
        case (tick_mode)
            0: tick_en = 1'b1;
            1: begin
                tick_en = (tick_phase == 0);
                tick_phase = (tick_phase + 1) % 4;
            end
            default: tick_en = ($urandom_range(3) != 0);
        endcase
    endtask

    task automatic wait_fs(input int limit, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!frame_start && cycles < limit);
        check("frame_start_seen", frame_start, 1'b1);
    endtask

    task automatic measure_high(output int h);
        h = 0;
        while (pwm_out && h < 3000) begin
            step();
            h++;
        end
    endtask

    task automatic send(input logic [7:0] pos);
        int n;
        pos_data = pos;
        pos_valid = 1'b1;
        n = 0;
        while (!pos_ready && n < 25000) begin
            step();
            n++;
        end
        check("send_ready_seen", pos_ready, 1'b1);
        step();
        pos_valid = 1'b0;
    endtask

    initial begin
        int c, h, n;
        vecs[0] = '{8'd0,   250};
        vecs[1] = '{8'd255, 500};
        vecs[2] = '{8'd100, 350};
        vecs[3] = '{8'd251, 500};
        vecs[4] = '{8'd1,   251};

        rst = 1'b1; tick_en = 1'b1; en = 1'b0; pos_valid = 1'b0; pos_data = '0;
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        #1;
        check("reset_pwm", pwm_out, 1'b0);
        check("reset_frame_start", frame_start, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_timeout", timeout, 1'b0);
        check("reset_ready", pos_ready, 1'b1);

        // Free-running frames with no command: center width.
        en = 1'b1;
        wait_fs(20, c);
        measure_high(h);
        check("default_width", h, c_center);
        wait_fs(12000, c);
        check("frame_period", h + c, c_frame);

        foreach (vecs[i]) begin
            send(vecs[i].pos);
            wait_fs(12000, c);
            measure_high(h);
            check("vector_width", h, vecs[i].width);
        end

        // Second command waits for the frame load of the first.
        send(8'd50);
        check("ready_low_when_full", pos_ready, 1'b0);
        pos_data = 8'd200;
        pos_valid = 1'b1;
        wait_fs(12000, c);
        check("ready_after_load", pos_ready, 1'b1);
        step();
        pos_valid = 1'b0;
        check("second_cmd_accepted", pos_ready, 1'b0);
        measure_high(h);
        check("first_cmd_width", h + 1, 300);
        wait_fs(12000, c);
        measure_high(h);
        check("second_cmd_width", h, 450);

        // en drop mid-frame lets the frame finish.
        wait_fs(12000, c);
        repeat (100) step();
        en = 1'b0;
        n = 100;
        while (busy && n < 6000) begin
            step();
            n++;
        end
        check("en_drop_frame_len", n, c_frame);
        check("idle_pwm_low", pwm_out, 1'b0);
        repeat (20) step();
        check("idle_holds", busy, 1'b0);
        en = 1'b1;
        step();
        check("restart_on_tick", frame_start, 1'b1);

        // Async reset mid-pulse, tick every 4th cycle.
        en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        tick_mode = 1;
        tick_phase = 0;
        send(8'd100);
        en = 1'b1;
        wait_fs(100, c);
        repeat (600) step();
        check("pulse_before_rst", pwm_out, 1'b1);
        pos_data = 8'd7;
        pos_valid = 1'b1;
        step();
        pos_valid = 1'b0;
        check("pending_full_before_rst", pos_ready, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_async_pwm", pwm_out, 1'b0);
        check("rst_async_ready", pos_ready, 1'b1);
        check("rst_async_busy", busy, 1'b0);
        en = 1'b0;
        step();
        rst = 1'b0;
        send(8'd100);
        en = 1'b1;
        wait_fs(100, c);
        measure_high(h);
        check("slow_tick_width", h, 1400);

        // Randomized traffic, checked cycle by cycle against the model.
        tick_mode = 2;
        repeat (20000) begin
            if ($urandom_range(2999) == 0) en = ~en;
            pos_valid = ($urandom_range(49) == 0);
            pos_data = 8'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
